// File: rtl/freq_meter.sv
// Square-wave period/frequency meter referenced to sysclk.
// Period is measured rise-to-rise; frequency is counted over a free-running gate window.
module freq_meter #(
    parameter int GATE_CYCLES    = 100_000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int PER_W          = 24,
    parameter int FRQ_W          = 16
) (
    input  logic             sysclk_i,
    input  logic             rst_i,
    input  logic             sig_in_i,
    output logic [PER_W-1:0] period_o,
    output logic             period_valid_o,
    output logic [FRQ_W-1:0] freq_count_o,
    output logic             freq_valid_o,
    output logic             timeout_o
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic {IDLE, MEASURE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         sync_q;  // [0]=s1, [1]=s2, [2]=s3 edge history
    logic               rise;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]   period_q, period_d;
    logic               pvalid_q, pvalid_d;
    logic               timeout_q, timeout_d;
    logic [GW-1:0]      gate_cnt_q, gate_cnt_d;
    logic [FRQ_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [FRQ_W-1:0]   edge_inc;
    logic [FRQ_W-1:0]   freq_q, freq_d;
    logic               fvalid_q, fvalid_d;
    logic               gate_close;

    assign rise = sync_q[1] & ~sync_q[2];

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            per_cnt_q  <= '0;
            period_q   <= '0;
            pvalid_q   <= 1'b0;
            timeout_q  <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            freq_q     <= '0;
            fvalid_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], sig_in_i};
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            period_q   <= period_d;
            pvalid_q   <= pvalid_d;
            timeout_q  <= timeout_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            freq_q     <= freq_d;
            fvalid_q   <= fvalid_d;
        end
    end

    // A rise in the timeout cycle takes priority and yields a normal measurement.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        pvalid_d  = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                per_cnt_d = '0;
                if (rise) begin
                    state_d   = MEASURE;
                    per_cnt_d = PER_W'(1);
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d  = per_cnt_q;
                    per_cnt_d = PER_W'(1);
                    pvalid_d  = 1'b1;
                end else if (per_cnt_q == PER_W'(TIMEOUT_CYCLES)) begin
                    state_d   = IDLE;
                    period_d  = '0;
                    timeout_d = 1'b1;
                    per_cnt_d = '0;
                end else begin
                    per_cnt_d = per_cnt_q + PER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A rise on the closing cycle belongs to the window being reported.
    always_comb begin
        gate_close = (gate_cnt_q == GW'(GATE_CYCLES - 1));
        edge_inc   = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + FRQ_W'(1) : edge_cnt_q;
        gate_cnt_d = gate_cnt_q + GW'(1);
        edge_cnt_d = edge_inc;
        freq_d     = freq_q;
        fvalid_d   = 1'b0;
        if (gate_close) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            freq_d     = edge_inc;
            fvalid_d   = 1'b1;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = pvalid_q;
    assign freq_count_o   = freq_q;
    assign freq_valid_o   = fvalid_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a main instance with scaled gate/timeout
// and a narrow-counter instance for freq_count saturation.
module tb_freq_meter;

    localparam int G   = 2000;
    localparam int T   = 5000;
    localparam int PW  = 16;
    localparam int FW  = 8;
    localparam int SG  = 1000;
    localparam int SFW = 4;

    logic          sysclk = 1'b0;
    logic          rst    = 1'b1;
    logic          sig    = 1'b0;
    logic [PW-1:0] period, s_period;
    logic          pv, s_pv, fv, s_fv, tmo, s_tmo;
    logic [FW-1:0] freq;
    logic [SFW-1:0] s_freq;

    always #5 sysclk = ~sysclk;

    freq_meter #(.GATE_CYCLES(G), .TIMEOUT_CYCLES(T), .PER_W(PW), .FRQ_W(FW)) dut (
        .sysclk_i(sysclk), .rst_i(rst), .sig_in_i(sig),
        .period_o(period), .period_valid_o(pv), .freq_count_o(freq),
        .freq_valid_o(fv), .timeout_o(tmo)
    );

    freq_meter #(.GATE_CYCLES(SG), .TIMEOUT_CYCLES(T), .PER_W(PW), .FRQ_W(SFW)) dut_sat (
        .sysclk_i(sysclk), .rst_i(rst), .sig_in_i(sig),
        .period_o(s_period), .period_valid_o(s_pv), .freq_count_o(s_freq),
        .freq_valid_o(s_fv), .timeout_o(s_tmo)
    );

    typedef struct {
        int per;
        int exp_frq;
        int exp_sat;
    } vec_t;

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, rel_cyc = 0, fv_cyc = 0, last_pv_cyc = 0, pv_cnt = 0;
    int   exp_per = 0, exp_frq = 0, exp_sat = 0;
    logic per_en = 0, per_skip = 0, frq_en = 0, sat_en = 0, first_fv_pending = 0;
    logic pv_now = 0, fv_now = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One sysclk cycle; outputs are sampled 1 ns after the edge and monitored here.
    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
        pv_now = pv;
        fv_now = fv;
        if (pv) begin
            pv_cnt++;
            last_pv_cyc = cyc;
            if (per_en) begin
                if (per_skip) per_skip = 0;
                else check("period", int'(period), exp_per);
            end
        end
        if (fv) begin
            fv_cyc = cyc;
            if (first_fv_pending) begin
                check("first_gate_latency", cyc - rel_cyc, G);
                first_fv_pending = 0;
            end
            if (frq_en) check("freq_count", int'(freq), exp_frq);
        end
        if (s_fv && sat_en) check("sat_freq_count", int'(s_freq), exp_sat);
    endtask

    task automatic wait_fv(input int lim);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!fv_now && n < lim);
        check("freq_valid_seen", int'(fv_now), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_pvalid"}, int'(pv), 0);
        check({tag, "_freq"}, int'(freq), 0);
        check({tag, "_fvalid"}, int'(fv), 0);
        check({tag, "_timeout"}, int'(tmo), 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   p0, n;

        vecs[0] = '{per: 20,   exp_frq: 100, exp_sat: 15};
        vecs[1] = '{per: 50,   exp_frq: 40,  exp_sat: 15};
        vecs[2] = '{per: 100,  exp_frq: 20,  exp_sat: 10};
        vecs[3] = '{per: 250,  exp_frq: 8,   exp_sat: 4};
        vecs[4] = '{per: 1000, exp_frq: 2,   exp_sat: 1};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        rel_cyc = cyc;
        first_fv_pending = 1;

        // First rise only arms; second gives period 1000
        repeat (10) tick();
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("first_rise_no_pv", pv_cnt - p0, 0);
        check("first_rise_timeout", int'(tmo), 0);
        per_en = 1; per_skip = 0; exp_per = 1000;
        repeat (490) tick();
        sig = 1'b0;
        repeat (500) tick();
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("second_rise_pv", pv_cnt - p0, 1);
        repeat (490) tick();
        sig = 1'b0;
        frq_en = 1; exp_frq = 2;
        wait_fv(G + 10);

        // Table: each entry runs exactly two gate windows, aligned to the gate
        foreach (vecs[i]) begin
            per_en = 1; per_skip = 1; exp_per = vecs[i].per;
            frq_en = 1; exp_frq = vecs[i].exp_frq;
            sat_en = 1; exp_sat = vecs[i].exp_sat;
            repeat (2 * G / vecs[i].per) begin
                sig = 1'b1;
                repeat (vecs[i].per / 2) tick();
                sig = 1'b0;
                repeat (vecs[i].per / 2) tick();
            end
            check("table_timeout_low", int'(tmo), 0);
        end

        // Loss of signal
        frq_en = 0; sat_en = 0;
        n = 0;
        while (!tmo && n < T + 2000) begin
            tick();
            n++;
        end
        check("timeout_asserted", int'(tmo), 1);
        check("timeout_latency", cyc - last_pv_cyc, T);
        check("timeout_period", int'(period), 0);

        // Recovery: first rise clears timeout silently, next measures 300
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("recover_timeout_clear", int'(tmo), 0);
        check("recover_no_pv", pv_cnt - p0, 0);
        exp_per = 300; per_skip = 0;
        repeat (140) tick();
        sig = 1'b0;
        repeat (150) tick();
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("recover_pv", pv_cnt - p0, 1);

        // Gate boundary: rise detected on the closing cycle
        sig = 1'b0;
        per_en = 0;
        wait_fv(G + 10);
        repeat (G - 3) tick();
        sig = 1'b1;
        repeat (3) tick();
        check("gate_edge_fvalid", int'(fv_now), 1);
        check("gate_edge_included", int'(freq), 1);
        repeat (50) tick();
        sig = 1'b0;
        wait_fv(G + 10);
        check("gate_next_excludes", int'(freq), 0);

        // Reset mid-measurement
        sig = 1'b1;
        repeat (250) tick();
        sig = 1'b0;
        repeat (250) tick();
        per_en = 1; per_skip = 0; exp_per = 500;
        sig = 1'b1;
        repeat (3) tick();
        check("pre_reset_pv", int'(pv_now), 1);
        repeat (247) tick();
        sig = 1'b0;
        repeat (153) tick();
        rst = 1'b1;
        tick();
        check_zero_outputs("midreset");
        rst = 1'b0;
        rel_cyc = cyc;
        first_fv_pending = 1;
        repeat (100) tick();
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("post_reset_no_pv", pv_cnt - p0, 0);
        exp_per = 700;
        repeat (340) tick();
        sig = 1'b0;
        repeat (350) tick();
        p0 = pv_cnt;
        sig = 1'b1;
        repeat (10) tick();
        check("post_reset_pv", pv_cnt - p0, 1);
        frq_en = 1; exp_frq = 2;
        wait_fv(G + 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
